// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the MIPS encoder and control decoder.
// Holds opcodes, the instruction-kind enumeration, field positions and packing helpers.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_ADDI = 4'd1,
        KIND_ANDI = 4'd2,
        KIND_ORI  = 4'd3,
        KIND_LUI  = 4'd4,
        KIND_LW   = 4'd5,
        KIND_SW   = 4'd6,
        KIND_BEQ  = 4'd7,
        KIND_BNE  = 4'd8,
        KIND_J    = 4'd9,
        KIND_JAL  = 4'd10
    } instrKind_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic logic [31:0] packR(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] shamt, input logic [5:0] funct);
        logic [31:0] w;
        w = '0;
        w[OP_MSB:OP_LSB]       = op;
        w[RS_MSB:RS_LSB]       = rs;
        w[RT_MSB:RT_LSB]       = rt;
        w[RD_MSB:RD_LSB]       = rd;
        w[SHAMT_MSB:SHAMT_LSB] = shamt;
        w[FUNCT_MSB:FUNCT_LSB] = funct;
        return w;
    endfunction

    function automatic logic [31:0] packI(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OP_MSB:OP_LSB]   = op;
        w[RS_MSB:RS_LSB]   = rs;
        w[RT_MSB:RT_LSB]   = rt;
        w[IMM_MSB:IMM_LSB] = imm;
        return w;
    endfunction

    function automatic logic [31:0] packJ(input logic [5:0] op, input logic [25:0] target);
        logic [31:0] w;
        w = '0;
        w[OP_MSB:OP_LSB]         = op;
        w[TARGET_MSB:TARGET_LSB] = target;
        return w;
    endfunction

    // Branches and jumps are the kinds that own a delay slot.
    function automatic logic isControlKind(input logic [3:0] kind);
        return (kind == KIND_BEQ) || (kind == KIND_BNE) || (kind == KIND_J) || (kind == KIND_JAL);
    endfunction

endpackage

// File: rtl/mips_field_pack.sv
// Combinational packer: turns an instruction kind plus fields into a MIPS machine word.
// Branch targets arrive as absolute word addresses and are converted to PC-relative offsets.
module mips_field_pack
    import mips_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [3:0]            kind,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           word,
    output logic                  illegal
);

    logic [ADDR_WIDTH:0] branchDiff;
    logic [15:0]         branchOff;

    // One extra bit keeps the difference signed so it sign-extends correctly into 16 bits.
    assign branchDiff = {1'b0, imm[ADDR_WIDTH-1:0]} - ({1'b0, addr} + (ADDR_WIDTH+1)'(1));
    assign branchOff  = 16'($signed(branchDiff));

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:    word = packR(OP_R, rs, rt, rd, shamt, funct);
            KIND_ADDI: word = packI(OP_ADDI, rs, rt, imm);
            KIND_ANDI: word = packI(OP_ANDI, rs, rt, imm);
            KIND_ORI:  word = packI(OP_ORI, rs, rt, imm);
            KIND_LUI:  word = packI(OP_LUI, 5'd0, rt, imm);
            KIND_LW:   word = packI(OP_LW, rs, rt, imm);
            KIND_SW:   word = packI(OP_SW, rs, rt, imm);
            KIND_BEQ:  word = packI(OP_BEQ, rs, rt, branchOff);
            KIND_BNE:  word = packI(OP_BNE, rs, rt, branchOff);
            KIND_J:    word = packJ(OP_J, target);
            KIND_JAL:  word = packJ(OP_JAL, target);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams encoded MIPS words with sequential addresses toward program memory.
// Define MIPS_ENC_DELAY_SLOT_EN to insert a NOP after every branch/jump word.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_word,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_PAD} encState_e;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    encState_e             state;
    logic [ADDR_WIDTH-1:0] nextAddr;
    logic [ADDR_WIDTH-1:0] outAddrReg;
    logic [31:0]           outWordReg;
    logic [31:0]           packedWord;
    logic                  outValidReg;
    logic                  errReg;
    logic                  packIllegal;
    logic                  padOwed;
    logic                  accept;
    logic                  outXfer;

    mips_field_pack #(.ADDR_WIDTH(ADDR_WIDTH)) fieldPack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .addr    (nextAddr),
        .word    (packedWord),
        .illegal (packIllegal)
    );

`ifdef MIPS_ENC_DELAY_SLOT_EN
    logic heldIsCtrl;
    // A held branch/jump already commits the next slot to a NOP, so intake stops early.
    assign padOwed = (state == ST_PAD) || ((state == ST_FULL) && heldIsCtrl);
`else
    assign padOwed = 1'b0;
`endif

    assign in_ready  = !reset && !flush && !padOwed && (!outValidReg || out_ready);
    assign accept    = in_valid && in_ready;
    assign outXfer   = outValidReg && out_ready;
    assign out_valid = outValidReg;
    assign out_word  = outWordReg;
    assign out_addr  = outAddrReg;
    assign err       = errReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            outValidReg <= 1'b0;
            outWordReg  <= '0;
            outAddrReg  <= BASE;
            nextAddr    <= BASE;
            errReg      <= 1'b0;
`ifdef MIPS_ENC_DELAY_SLOT_EN
            heldIsCtrl  <= 1'b0;
`endif
        end else if (flush) begin
            state       <= ST_EMPTY;
            outValidReg <= 1'b0;
            outWordReg  <= '0;
            outAddrReg  <= BASE;
            nextAddr    <= BASE;
            errReg      <= 1'b0;
`ifdef MIPS_ENC_DELAY_SLOT_EN
            heldIsCtrl  <= 1'b0;
`endif
        end else begin
            if (accept && packIllegal) begin
                errReg <= 1'b1;
            end
            case (state)
                ST_EMPTY, ST_FULL: begin
                    if (accept && !packIllegal) begin
                        state       <= ST_FULL;
                        outValidReg <= 1'b1;
                        outWordReg  <= packedWord;
                        outAddrReg  <= nextAddr;
                        nextAddr    <= nextAddr + ADDR_WIDTH'(1);
`ifdef MIPS_ENC_DELAY_SLOT_EN
                        heldIsCtrl  <= isControlKind(in_kind);
`endif
                    end else if (outXfer) begin
`ifdef MIPS_ENC_DELAY_SLOT_EN
                        if (heldIsCtrl) begin
                            state      <= ST_PAD;
                            outWordReg <= '0;
                            outAddrReg <= nextAddr;
                            nextAddr   <= nextAddr + ADDR_WIDTH'(1);
                            heldIsCtrl <= 1'b0;
                        end else begin
                            state       <= ST_EMPTY;
                            outValidReg <= 1'b0;
                        end
`else
                        state       <= ST_EMPTY;
                        outValidReg <= 1'b0;
`endif
                    end
                end
                ST_PAD: begin
                    if (outXfer) begin
                        state       <= ST_EMPTY;
                        outValidReg <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    outValidReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed literal checks plus a randomized run
// compared every cycle against a queue-based model of the emitted word stream.
module tb_mips_instr_encoder;

    localparam int AW   = 8;
    localparam int BASE = 0;
`ifdef MIPS_ENC_DELAY_SLOT_EN
    localparam bit PAD_MODE = 1'b1;
`else
    localparam bit PAD_MODE = 1'b0;
`endif
    localparam int OPS [11] = '{'h00, 'h08, 'h0C, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_kind = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_word;
    logic [AW-1:0] out_addr;
    logic          err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]   w;
        logic [AW-1:0] a;
        bit            blocks;
    } entry_t;

    entry_t expQ[$];
    int     mAddr = BASE;
    bit     mErr  = 1'b0;

    mips_instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the opcode map, using plain arithmetic.
    function automatic logic [31:0] modelEncode(int kind, int rs, int rt, int rd, int shamt,
                                                int funct, int imm, int target, int addr);
        longint v;
        int off;
        int m;
        v = longint'(OPS[kind]) * 64'd67108864;
        if (kind == 0) begin
            v += rs * 2097152 + rt * 65536 + rd * 2048 + shamt * 64 + funct;
        end else if (kind >= 1 && kind <= 6) begin
            v += (kind == 4 ? 0 : rs) * 2097152 + rt * 65536 + imm;
        end else if (kind == 7 || kind == 8) begin
            m   = 2 ** (AW + 1);
            off = (imm % (2 ** AW)) - addr - 1;
            off = ((off % m) + m) % m;
            if (off >= m / 2) off -= m;
            v += rs * 2097152 + rt * 65536 + (off & 'hFFFF);
        end else begin
            v += target;
        end
        return 32'(v);
    endfunction

    always @(negedge clk) begin
        bit rdyExp;
        int k;
        entry_t e;
        if (reset) begin
            checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
            checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_out_word", out_word, 32'h0);
            checkOutput("reset_out_addr", 32'(out_addr), 32'(BASE));
            checkOutput("reset_err", 32'(err), 32'd0);
            expQ.delete();
            mAddr = BASE;
            mErr  = 1'b0;
        end else begin
            rdyExp = !flush && (expQ.size() == 0 ||
                     (expQ.size() == 1 && out_ready && !expQ[0].blocks));
            checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                checkOutput("out_word", out_word, expQ[0].w);
                checkOutput("out_addr", 32'(out_addr), 32'(expQ[0].a));
            end
            checkOutput("in_ready", 32'(in_ready), 32'(rdyExp));
            checkOutput("err", 32'(err), 32'(mErr));
            if (flush) begin
                expQ.delete();
                mAddr = BASE;
                mErr  = 1'b0;
            end else begin
                if (expQ.size() != 0 && out_ready) void'(expQ.pop_front());
                if (in_valid && rdyExp) begin
                    k = int'(in_kind);
                    if (k > 10) begin
                        mErr = 1'b1;
                    end else begin
                        e.w = modelEncode(k, int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt),
                                          int'(in_funct), int'(in_imm), int'(in_target), mAddr);
                        e.a = AW'(mAddr);
                        e.blocks = PAD_MODE && (k >= 7);
                        expQ.push_back(e);
                        mAddr = (mAddr + 1) % (2 ** AW);
                        if (PAD_MODE && k >= 7) begin
                            e.w = 32'h0;
                            e.a = AW'(mAddr);
                            e.blocks = 1'b1;
                            expQ.push_back(e);
                            mAddr = (mAddr + 1) % (2 ** AW);
                        end
                    end
                end
            end
        end
    end

    // Presents one description and holds it until accepted; called just after a rising edge.
    task automatic applyStimulus(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                                 input logic [15:0] imm, input logic [25:0] target);
        bit acc;
        int n;
        in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
        in_funct = funct; in_imm = imm; in_target = target;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        int r;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        applyStimulus(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
        @(negedge clk);
        checkOutput("addi_word", out_word, 32'h20080005);
        checkOutput("addi_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;

        applyStimulus(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'd0);
        @(negedge clk);
        checkOutput("r_word", out_word, 32'h01095020);
        checkOutput("r_addr", 32'(out_addr), 32'd1);
        @(posedge clk); #1;

        applyStimulus(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
        applyStimulus(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0F0F, 26'd0);
        applyStimulus(4'd7, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0);
        @(negedge clk);
        checkOutput("beq_word", out_word, 32'h1109FFFD);
        checkOutput("beq_addr", 32'(out_addr), 32'd4);
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end

        out_ready = 1'b0;
        applyStimulus(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        in_kind = 4'd3; in_rs = 5'd5; in_rt = 5'd6; in_imm = 16'hABCD;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_word", out_word, 32'h20221234);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        applyStimulus(4'd3, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'd0);
        repeat (2) begin @(posedge clk); #1; end

        applyStimulus(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0);
        @(negedge clk);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        applyStimulus(4'd2, 5'd7, 5'd7, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
        @(negedge clk);
        checkOutput("after_illegal_addr", 32'(out_addr), PAD_MODE ? 32'd8 : 32'd7);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_err", 32'(err), 32'd0);
        checkOutput("flush_addr", 32'(out_addr), 32'(BASE));
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

`ifdef MIPS_ENC_DELAY_SLOT_EN
        applyStimulus(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10);
        @(negedge clk);
        checkOutput("j_word", out_word, 32'h08000010);
        checkOutput("j_addr", 32'(out_addr), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("nop_word", out_word, 32'h00000000);
        checkOutput("nop_addr", 32'(out_addr), 32'd1);
        @(posedge clk); #1;
        applyStimulus(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
        @(negedge clk);
        checkOutput("after_nop_addr", 32'(out_addr), 32'd2);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            r         = $urandom_range(0, 19);
            in_kind   = (r < 18) ? 4'(r % 11) : 4'(11 + $urandom_range(0, 4));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_funct  = 6'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            reset     = (i == 1500);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential instruction encoder for the single-cycle MIPS processor. It is the inverse of the control decoder: it accepts a decoded instruction description (kind plus fields) over a valid/ready handshake. It packs the description into a 32-bit machine word using the processor's opcode map and streams the words, with sequential word addresses, toward program memory for test loading. For branches it computes the PC-relative offset from an absolute target address.

## Interface
- ADDR_WIDTH, 8: word-address width of program memory; legal range 2..15.
- BASE_ADDR, 0: word address assigned after reset or flush.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the address counter, output register, pad state and err.
- in_valid  in  1  an instruction description is presented.
- in_ready  out  1  the encoder accepts the description this cycle.
- in_kind  in  4  0 R, 1 ADDI, 2 ANDI, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 JAL; 11..15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate; for BEQ/BNE, absolute target word address (low ADDR_WIDTH bits used).
- in_target  in  26  J/JAL word target.
- out_valid  out  1  out_word and out_addr are valid.
- out_ready  in  1  the consumer takes the word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  word address of out_word.
- err  out  1  sticky flag for an illegal kind.

## Operation
- **Opcodes:** R 0x00, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- **R format:** op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
- **I format:** op, rs, rt, imm[15:0]. LUI forces rs to 0.
- **J format:** op, in_target[25:0].
- **Branch offset:** target − (addr+1), computed in ADDR_WIDTH+1 bits as two's complement, then sign-extended to 16 bits.
- **Address counter:** starts at BASE_ADDR and increments by 1 per emitted word. It wraps from 2^ADDR_WIDTH−1 to 0.
- **Illegal kind:** the handshake completes, nothing is emitted, the counter is unchanged and err sets. err clears only on reset or flush.
- **Handshake rules:**
  - in_ready = !reset && !flush && !pad_owed && (!out_valid || out_ready).
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- **State machine:**
  - EMPTY → FULL on a legal accept.
  - FULL → EMPTY on an output transfer with no accept.
  - FULL → FULL on a simultaneous output transfer and accept.
  - FULL → PAD (config only) when a branch or jump word transfers out.
- **Flush:** forces EMPTY and out_valid=0, sets the counter to BASE_ADDR and clears err. Flush wins over a simultaneous accept.

## Timing
- **Reset values:** out_valid 0, out_word 0x00000000, out_addr BASE_ADDR, err 0, in_ready 0 while reset is high, state EMPTY.
- **Latency:** 1 cycle from the accept edge to out_valid and out_word.
- **Throughput:** 1 word/clk while out_ready is held high.
- **Stalls:** out_word and out_addr stay stable while out_valid && !out_ready.
- **Reset mid-transfer:** the held word is discarded and no partial state survives.

## Configuration
- **MIPS_ENC_DELAY_SLOT_EN defined:**
  - After each BEQ/BNE/J/JAL word transfers out, the block emits a NOP (0x00000000) at the next address.
  - in_ready stays low while the NOP is owed.
  - The branch offset is still computed relative to the branch's addr+1.
- **Undefined:** the PAD state is absent and no NOP is inserted.

## Structure
- **Package mips_isa_pkg:** opcode constants, the in_kind enumeration, and field bit positions. The package is shared with the control decoder.
- **Sub-module mips_field_pack:** combinational; takes kind, fields and current address and returns word plus illegal flag. The parent holds the FSM, counter and handshake.

## Test plan
- Reset, then ADDI rs=0 rt=8 imm=0x0005 → out_word 0x20080005, out_addr 0, 1 cycle later.
- R rs=8 rt=9 rd=10 shamt=0 funct=0x20 at addr 1 → 0x01095020, out_addr 1.
- BEQ rs=8 rt=9 target=2 issued at addr 4 → offset −3, out_word 0x1109FFFD.
- out_ready low 3 cycles with in_valid high → out_word stable and in_ready 0. Release → 1 word/clk resumes with no loss or duplication.
- in_kind 12 → err=1, no out_valid, next legal word keeps the same address. Flush → err=0, addr BASE_ADDR.
- With MIPS_ENC_DELAY_SLOT_EN: J target 0x10 at addr 0 → 0x08000010@0, then 0x00000000@1, next instruction @2.
